// File: rtl/io_pkg.sv
// Register offsets and the seven-segment decoder shared by the I/O controller.
// Combinational helper only; no state and no flow control.
package io_pkg;

  localparam logic [7:0] OFS_LED     = 8'h00;
  localparam logic [7:0] OFS_IN_RDY  = 8'h04;
  localparam logic [7:0] OFS_SW_DATA = 8'h08;
  localparam logic [7:0] OFS_SEG     = 8'h0C;
  localparam logic [7:0] OFS_CYCLE   = 8'h10;

  // Active-low segment code, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/io_ctrl_debouncer.sv
// Button synchronizer + debouncer; level follows din after DEBOUNCE_CYCLES stable samples.
// rise is a registered 1-cycle pulse one cycle after level goes high; no backpressure.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      level_q <= level;
      rise    <= level & ~level_q;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped LED/switch/seven-segment controller with a debounced commit handshake.
// Writes take effect at the next edge, io_din is zero-latency combinational; no backpressure.
module io_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  logic [7:0]     ofs;
  logic           unused_addr;
  logic           unused_btn_level;
  logic           commit;
  logic           ack;
  logic           take;
  logic [31:0]    seg_reg;
  logic [31:0]    cycle;
  logic [15:0]    sw_data;
  logic           in_ready;
  logic [SCW-1:0] scan_cnt;
  logic [2:0]     digit;

  assign ofs         = io_addr[7:0];
  assign unused_addr = ^io_addr[31:8];

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .level(unused_btn_level),
    .rise (commit)
  );

  // An acknowledge in the same cycle as a commit lets the new sample through.
  assign ack  = io_we && (ofs == OFS_IN_RDY);
  assign take = commit && (!in_ready || ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      seg_reg  <= '0;
      sw_data  <= '0;
      in_ready <= 1'b0;
      cycle    <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (io_we && (ofs == OFS_LED)) led <= io_dout[15:0];
      if (io_we && (ofs == OFS_SEG)) seg_reg <= io_dout;
      if (take) begin
        sw_data  <= sw;
        in_ready <= 1'b1;
      end else if (ack) begin
        in_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  always_comb begin
    io_din = '0;
    case (ofs)
      OFS_LED:     io_din = {16'b0, led};
      OFS_IN_RDY:  io_din = {31'b0, in_ready};
      OFS_SW_DATA: io_din = {16'b0, sw_data};
      OFS_SEG:     io_din = seg_reg;
      OFS_CYCLE:   io_din = cycle;
      default:     io_din = '0;
    endcase
  end

  assign an  = ~(8'b1 << digit);
  assign seg = hex7seg(seg_reg[{digit, 2'b00} +: 4]);

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Memory-mapped I/O controller on the CPU's io_bus, downstream of the pipelined core. It decodes stores whose address has bit 10 set (io_we) into the LED and seven-segment registers. It returns switch data, handshake flags and a cycle counter on io_din for loads, which the core's MEM stage consumes. It also debounces the board's commit button and multiplexes an 8-digit seven-segment display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required before the debounced button level changes.
- SCAN_DIV, 100_000: clk cycles per display digit.

Ports:
- clk  in  1  system clock; the same clock as the core.
- rst  in  1  reset, asynchronous and active-high.
- io_addr  in  32  byte address from the core; only bits [7:0] are decoded.
- io_dout  in  32  store data from the core.
- io_we  in  1  store strobe, already qualified by io_addr[10].
- io_din  out  32  load data to the core; combinational.
- sw  in  16  board switches; asynchronous.
- btn  in  1  commit button; asynchronous and bouncing.
- led  out  16  LED drive.
- an  out  8  digit enables, active-low.
- seg  out  7  segments {g..a}, active-low.

## Operation
Register map (offset = io_addr[7:0]):
- 0x00 LED (R/W): a write stores io_dout[15:0]; a read returns {16'b0, led}.
- 0x04 IN_RDY (R/W): a read returns {31'b0, in_ready}; any write clears in_ready (acknowledge).
- 0x08 SW_DATA (R): returns {16'b0, latched switch value}.
- 0x0C SEG (R/W): a write stores the full 32-bit io_dout; a read returns the stored value.
- 0x10 CYCLE (R): free-running 32-bit cycle counter.
- Any other offset: reads return 0; writes are ignored. Writes to read-only offsets are ignored.

Input handshake:
- btn passes through a 2-FF synchronizer and then the debouncer. The debounced level toggles only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it.
- A rising edge of the debounced level produces a 1-cycle `commit` pulse.
- While in_ready=0, a `commit` pulse latches sw into SW_DATA and sets in_ready=1.
- While in_ready=1, a `commit` pulse is ignored; SW_DATA stays stable until acknowledged.
- If a `commit` pulse and an IN_RDY write occur in the same cycle, set wins: SW_DATA latches the new sw value and in_ready stays 1.
- Reads have no side effects. This is required because a stalled core may present the same load address for several cycles.

Display:
- A scan counter counts 0..SCAN_DIV-1. On wrap, the digit index (0..7) increments modulo 8.
- an drives a 0 only at bit[index].
- seg = hex7seg(SEG[4*index+3 : 4*index]).

Arithmetic:
- CYCLE increments every clk and wraps 0xFFFFFFFF→0.
- All counters are unsigned and wrap silently.

## Timing
- A write at posedge N (io_we=1) is visible on led, the register, and io_din from after posedge N.
- io_din depends combinationally on io_addr and the current register state, with zero-cycle latency. This lets the MEMWB stage capture it at the next edge.
- Button latency from btn stable to commit pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- in_ready rises on the cycle after the commit pulse.
- Reset (asynchronous, at any time, including mid-debounce or mid-scan) forces:
  - led=0, SEG=0, SW_DATA=0, in_ready=0, CYCLE=0;
  - synchronizer, debounce state and counter=0; scan counter=0, index=0;
  - an=8'b1111_1110, seg=7'b1000000 ('0').
- After deassertion, CYCLE reads 1 on the first cycle after the first posedge.

## Structure
- Package io_pkg holds:
  - offset constants: OFS_LED, OFS_IN_RDY, OFS_SW_DATA, OFS_SEG, OFS_CYCLE;
  - function hex7seg(4-bit) → 7-bit active-low code.
- Sub-module `debouncer` (parameter DEBOUNCE_CYCLES; ports clk, rst, din, level, rise) contains the synchronizer, stable counter and edge detector.
- io_ctrl instantiates one debouncer. It holds the register file, the handshake logic, the read mux and the scan logic.

## Test plan
Run with DEBOUNCE_CYCLES=4 and SCAN_DIV=2.
- Reset, then write 0x00 with 0xDEAD_BEEF → led=0xBEEF; a read of 0x00 returns 0x0000_BEEF; reads of 0x14 return 0.
- sw=0x1234, btn bounces 1-0-1 for 3 cycles then holds 1 → exactly one commit pulse, 7 cycles after the stable 1; then IN_RDY reads 1 and SW_DATA reads 0x1234.
- With in_ready=1: sw=0x5678 and a second press → SW_DATA stays 0x1234. Then write 0x04 → IN_RDY reads 0.
- Commit pulse and a 0x04 write in the same cycle with sw=0x9ABC → in_ready=1 and SW_DATA=0x9ABC.
- Write 0x0C with 0x7654_3210 → over 16 cycles, an steps FE,FD,…,7F with seg showing '0','1',…,'7'; the sequence then wraps.
- Assert rst mid-scan and mid-debounce → all outputs take their reset values immediately; CYCLE restarts from 0 and no spurious commit pulse occurs.
